// File: rtl/ladybird_boot_loader.sv
// Boot loader for ladybird_core: packs a byte stream into 32-bit words with strobes and
// writes them over AXI4-Lite, then releases the core with the captured entry PC.
module ladybird_boot_loader #(
   parameter int AXI_ADDR_W = 32,
   parameter int AXI_DATA_W = 32,
   parameter int XLEN       = 32
) (
   input  logic                   clk,
   input  logic                   nrst,
   input  logic                   load_valid,
   output logic                   load_ready,
   input  logic [AXI_ADDR_W-1:0]  load_addr,
   input  logic [7:0]             load_data,
   input  logic                   load_last,
   input  logic [XLEN-1:0]        entry_pc,
   output logic                   awvalid,
   input  logic                   awready,
   output logic [AXI_ADDR_W-1:0]  awaddr,
   output logic                   wvalid,
   input  logic                   wready,
   output logic [AXI_DATA_W-1:0]  wdata,
   output logic [AXI_DATA_W/8-1:0] wstrb,
   input  logic                   bvalid,
   output logic                   bready,
   input  logic [1:0]             bresp,
   output logic                   start,
   output logic [XLEN-1:0]        start_pc,
   output logic                   busy,
   output logic                   error
);

   localparam int NB = AXI_DATA_W / 8;

   typedef enum logic [1:0] {
      S_COLLECT = 2'd0,
      S_ISSUE   = 2'd1,
      S_RESP    = 2'd2,
      S_START   = 2'd3
   } state_t;

   state_t                  state_reg, state_next;
   logic [AXI_ADDR_W-3:0]   wa_reg, wa_next;
   logic [AXI_DATA_W-1:0]   data_reg, data_next, data_merged;
   logic [NB-1:0]           strb_reg, strb_next, strb_merged, lane_bit;
   logic                    last_reg, last_next;
   logic [XLEN-1:0]         pc_reg, pc_next;
   logic [XLEN-1:0]         start_pc_reg, start_pc_next;
   logic                    aw_done_reg, aw_done_next;
   logic                    w_done_reg, w_done_next;
   logic                    busy_reg, busy_next;
   logic                    error_reg, error_next;

   logic [1:0] lane;
   logic       buf_empty, mergeable, accept;
   logic       aw_fire, w_fire, aw_all, w_all;

   assign lane      = load_addr[1:0];
   assign buf_empty = (strb_reg == '0);
   assign mergeable = buf_empty || ((load_addr[AXI_ADDR_W-1:2] == wa_reg) && !strb_reg[lane]);
   assign accept    = (state_reg == S_COLLECT) && load_valid && mergeable;
   assign lane_bit  = NB'(1) << lane;
   assign strb_merged = strb_reg | lane_bit;

   // Only the addressed lane takes the incoming byte; the others keep their buffered value.
   for (genvar gi = 0; gi < NB; gi++) begin : g_lane
      assign data_merged[gi*8 +: 8] = (lane == 2'(gi)) ? load_data : data_reg[gi*8 +: 8];
   end

   assign load_ready = nrst && (state_reg == S_COLLECT) && mergeable;
   assign awvalid    = (state_reg == S_ISSUE) && !aw_done_reg;
   assign wvalid     = (state_reg == S_ISSUE) && !w_done_reg;
   assign bready     = (state_reg == S_RESP);
   assign start      = (state_reg == S_START);
   assign awaddr     = {wa_reg, 2'b00};
   assign wdata      = data_reg;
   assign wstrb      = strb_reg;
   assign start_pc   = start_pc_reg;
   assign busy       = busy_reg;
   assign error      = error_reg;

   assign aw_fire = awvalid && awready;
   assign w_fire  = wvalid && wready;
   assign aw_all  = aw_done_reg || aw_fire;
   assign w_all   = w_done_reg || w_fire;

   always_comb begin
      state_next    = state_reg;
      wa_next       = wa_reg;
      data_next     = data_reg;
      strb_next     = strb_reg;
      last_next     = last_reg;
      pc_next       = pc_reg;
      start_pc_next = start_pc_reg;
      aw_done_next  = aw_done_reg;
      w_done_next   = w_done_reg;
      busy_next     = busy_reg;
      error_next    = error_reg;
      case (state_reg)
         S_COLLECT: begin
            if (accept) begin
               if (buf_empty) wa_next = load_addr[AXI_ADDR_W-1:2];
               strb_next = strb_merged;
               data_next = data_merged;
               busy_next = 1'b1;
               if (load_last) begin
                  last_next = 1'b1;
                  pc_next   = entry_pc;
               end
               if (strb_merged == '1 || load_last) state_next = S_ISSUE;
            end else if (load_valid) begin
               // Byte cannot join this word: flush and hold it until the buffer is empty.
               state_next = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (aw_all && w_all) begin
               aw_done_next = 1'b0;
               w_done_next  = 1'b0;
               state_next   = S_RESP;
            end else begin
               aw_done_next = aw_all;
               w_done_next  = w_all;
            end
         end
         S_RESP: begin
            if (bvalid) begin
               error_next = error_reg || (bresp != 2'b00);
               strb_next  = '0;
               data_next  = '0;
               if (last_reg) begin
                  start_pc_next = pc_reg;
                  busy_next     = 1'b0;
                  state_next    = S_START;
               end else begin
                  state_next = S_COLLECT;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_reg    <= S_COLLECT;
         wa_reg       <= '0;
         data_reg     <= '0;
         strb_reg     <= '0;
         last_reg     <= 1'b0;
         pc_reg       <= '0;
         start_pc_reg <= '0;
         aw_done_reg  <= 1'b0;
         w_done_reg   <= 1'b0;
         busy_reg     <= 1'b0;
         error_reg    <= 1'b0;
      end else begin
         state_reg    <= state_next;
         wa_reg       <= wa_next;
         data_reg     <= data_next;
         strb_reg     <= strb_next;
         last_reg     <= last_next;
         pc_reg       <= pc_next;
         start_pc_reg <= start_pc_next;
         aw_done_reg  <= aw_done_next;
         w_done_reg   <= w_done_next;
         busy_reg     <= busy_next;
         error_reg    <= error_next;
      end
   end

endmodule
